// File: rtl/shunt_yard_pkg.sv
// Token and operator codes shared by the shunting-yard converter and its
// precedence helper, plus the converter state encoding.
package shunt_yard_pkg;

    localparam int CO_N = 3;

    localparam logic [CO_N-1:0] CO_LP = 3'd1;
    localparam logic [CO_N-1:0] CO_RP = 3'd2;
    localparam logic [CO_N-1:0] CO_AD = 3'd3;
    localparam logic [CO_N-1:0] CO_SB = 3'd4;
    localparam logic [CO_N-1:0] CO_MU = 3'd5;
    localparam logic [CO_N-1:0] CO_DI = 3'd6;

    localparam logic [1:0] TK_NUM = 2'b00;
    localparam logic [1:0] TK_OP  = 2'b01;
    localparam logic [1:0] TK_END = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_POPRP,
        ST_FLUSH,
        ST_DRAIN,
        ST_ERR
    } state_t;

    // Binding strength; CO_LP ranks lowest so an open paren always blocks popping.
    function automatic logic [1:0] op_prec(input logic [CO_N-1:0] op);
        case (op)
            CO_AD, CO_SB: op_prec = 2'd1;
            CO_MU, CO_DI: op_prec = 2'd2;
            default:      op_prec = 2'd0;
        endcase
    endfunction

    function automatic logic op_left_assoc(input logic [CO_N-1:0] op);
        case (op)
            CO_AD, CO_SB, CO_MU, CO_DI: op_left_assoc = 1'b1;
            default:                    op_left_assoc = 1'b0;
        endcase
    endfunction

    function automatic logic is_arith(input logic [CO_N-1:0] op);
        is_arith = (op == CO_AD) || (op == CO_SB) || (op == CO_MU) || (op == CO_DI);
    endfunction

endpackage

// File: rtl/shunt_yard_precedence.sv
// Pop decision for the shunting-yard: lle_rlt is 1 when the stacked operator B
// must be emitted before the incoming operator A is pushed.
module shunt_yard_precedence
    import shunt_yard_pkg::*;
(
    input  logic [CO_N-1:0] op_a,
    input  logic [CO_N-1:0] op_b,
    output logic            lle_rlt
);

    logic [1:0] prec_a;
    logic [1:0] prec_b;

    // Left-associative A pops on equal precedence, right-associative A only on strictly higher B.
    always_comb begin
        prec_a  = op_prec(op_a);
        prec_b  = op_prec(op_b);
        lle_rlt = op_left_assoc(op_a) ? (prec_a <= prec_b) : (prec_a < prec_b);
    end

endmodule

// File: rtl/shunt_yard.sv
// Infix-to-postfix token converter: numbers pass straight to the output slot,
// operators wait on an internal stack and leave in postfix order.
module shunt_yard
    import shunt_yard_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [CO_N-1:0] in_op,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_kind,
    output logic [CO_N-1:0] out_op,
    output logic [DW-1:0]   out_data,
    output logic            err
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    state_t          state;
    logic [SPW-1:0]  sp;
    logic [CO_N-1:0] stack [DEPTH];
    logic [CO_N-1:0] pend_op;
    logic [IW-1:0]   top_idx;
    logic [CO_N-1:0] top_op;
    logic            stack_empty;
    logic            stack_full;
    logic            slot_free;
    logic            in_fire;
    logic            lle_rlt;

    assign top_idx     = sp[IW-1:0] - IW'(1);
    assign top_op      = stack[top_idx];
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign slot_free   = !out_valid || out_ready;
    assign in_ready    = (state == ST_ERR) || ((state == ST_IDLE) && slot_free);
    assign in_fire     = in_valid && in_ready;

    shunt_yard_precedence precedence (
        .op_a    (pend_op),
        .op_b    (top_op),
        .lle_rlt (lle_rlt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sp        <= '0;
            pend_op   <= '0;
            out_valid <= 1'b0;
            out_kind  <= TK_NUM;
            out_op    <= '0;
            out_data  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            // Handing off the END that closes an errored expression clears err.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (out_kind == TK_END) begin
                    err <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        case (in_kind)
                            TK_NUM: begin
                                out_valid <= 1'b1;
                                out_kind  <= TK_NUM;
                                out_op    <= '0;
                                out_data  <= in_data;
                            end
                            TK_OP: begin
                                if (in_op == CO_LP) begin
                                    if (stack_full) begin
                                        err   <= 1'b1;
                                        sp    <= '0;
                                        state <= ST_ERR;
                                    end else begin
                                        stack[sp[IW-1:0]] <= CO_LP;
                                        sp                <= sp + SPW'(1);
                                    end
                                end else if (in_op == CO_RP) begin
                                    if (stack_empty) begin
                                        err   <= 1'b1;
                                        sp    <= '0;
                                        state <= ST_ERR;
                                    end else begin
                                        state <= ST_POPRP;
                                    end
                                end else if (is_arith(in_op)) begin
                                    pend_op <= in_op;
                                    state   <= ST_PEND;
                                end
                            end
                            TK_END: state <= ST_FLUSH;
                            default: ;
                        endcase
                    end
                end

                ST_PEND: begin
                    if (!stack_empty && lle_rlt) begin
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            out_kind  <= TK_OP;
                            out_op    <= top_op;
                            out_data  <= '0;
                            sp        <= sp - SPW'(1);
                        end
                    end else if (stack_full) begin
                        err   <= 1'b1;
                        sp    <= '0;
                        state <= ST_ERR;
                    end else begin
                        stack[sp[IW-1:0]] <= pend_op;
                        sp                <= sp + SPW'(1);
                        state             <= ST_IDLE;
                    end
                end

                ST_POPRP: begin
                    if (stack_empty) begin
                        err   <= 1'b1;
                        sp    <= '0;
                        state <= ST_ERR;
                    end else if (top_op == CO_LP) begin
                        sp    <= sp - SPW'(1);
                        state <= ST_IDLE;
                    end else if (slot_free) begin
                        out_valid <= 1'b1;
                        out_kind  <= TK_OP;
                        out_op    <= top_op;
                        out_data  <= '0;
                        sp        <= sp - SPW'(1);
                    end
                end

                ST_FLUSH: begin
                    if (stack_empty) begin
                        state <= ST_DRAIN;
                    end else if (top_op == CO_LP) begin
                        err   <= 1'b1;
                        sp    <= '0;
                        state <= ST_ERR;
                    end else if (slot_free) begin
                        out_valid <= 1'b1;
                        out_kind  <= TK_OP;
                        out_op    <= top_op;
                        out_data  <= '0;
                        sp        <= sp - SPW'(1);
                    end
                end

                ST_DRAIN: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_kind  <= TK_END;
                        out_op    <= '0;
                        out_data  <= '0;
                        state     <= ST_IDLE;
                    end
                end

                ST_ERR: begin
                    if (in_fire && (in_kind == TK_END)) begin
                        state <= ST_DRAIN;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shunt_yard.sv
// Directed bench for shunt_yard: drives infix token streams and compares the
// collected postfix output against hand-written expected token lists.
module tb_shunt_yard;
    import shunt_yard_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [1:0]      in_kind   = TK_NUM;
    logic [CO_N-1:0] in_op     = '0;
    logic [DW-1:0]   in_data   = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      out_kind;
    logic [CO_N-1:0] out_op;
    logic [DW-1:0]   out_data;
    logic            err;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [63:0] out_q[$];
    logic [63:0] exp_q[$];
    bit          toggle_mode  = 1'b0;
    bit          err_seen     = 1'b0;

    shunt_yard #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_op    (out_op),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack_tok(input logic [1:0] k, input logic [CO_N-1:0] op,
                                             input logic [DW-1:0] d);
        return 64'({k, op, d});
    endfunction

    // Values on the bus at the falling edge are what the next rising edge hands off.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) out_q.push_back(pack_tok(out_kind, out_op, out_data));
        if (err) err_seen = 1'b1;
    end

    initial begin
        int phase = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                out_ready = pat[phase];
                phase     = (phase + 1) % 4;
            end else begin
                out_ready = 1'b1;
                phase     = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic applyStimulus(input logic [1:0] kind, input logic [CO_N-1:0] op, input logic [DW-1:0] data);
        int waited = 0;
        in_valid = 1'b1;
        in_kind  = kind;
        in_op    = op;
        in_data  = data;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic startCase();
        out_q.delete();
        exp_q.delete();
        err_seen = 1'b0;
    endtask

    task automatic expNum(input logic [DW-1:0] d);
        exp_q.push_back(pack_tok(TK_NUM, '0, d));
    endtask

    task automatic expOp(input logic [CO_N-1:0] op);
        exp_q.push_back(pack_tok(TK_OP, op, '0));
    endtask

    task automatic expEnd();
        exp_q.push_back(pack_tok(TK_END, '0, '0));
    endtask

    task automatic waitDrain(input string tag);
        int cycles = 0;
        while (out_q.size() < exp_q.size() && cycles < 300) begin
            @(posedge clk);
            cycles++;
        end
        repeat (6) @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < out_q.size()) checkOutput($sformatf("%s_tok%0d", tag, i), out_q[i], exp_q[i]);
        end
    endtask

    task automatic sendSimple();
        applyStimulus(TK_NUM, '0, 32'd1);
        applyStimulus(TK_OP, CO_AD, '0);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_OP, CO_MU, '0);
        applyStimulus(TK_NUM, '0, 32'd3);
        applyStimulus(TK_END, '0, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_out_fields", pack_tok(out_kind, out_op, out_data), 64'd0);
        checkOutput("rst_sp", 64'(dut.sp), 64'd0);

        // 1 + 2 * 3 END, with latency checks on the first number and operator
        startCase();
        expNum(32'd1); expNum(32'd2); expNum(32'd3); expOp(CO_MU); expOp(CO_AD); expEnd();
        applyStimulus(TK_NUM, '0, 32'd1);
        checkOutput("num_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("num_latency_data", 64'(out_data), 64'd1);
        applyStimulus(TK_OP, CO_AD, '0);
        checkOutput("op_pend_busy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("op_ready_back", 64'(in_ready), 64'd1);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_OP, CO_MU, '0);
        applyStimulus(TK_NUM, '0, 32'd3);
        applyStimulus(TK_END, '0, '0);
        waitDrain("simple");
        checkOutput("simple_err", 64'(err_seen), 64'd0);

        // ( 1 + 2 ) * 3 END
        startCase();
        expNum(32'd1); expNum(32'd2); expOp(CO_AD); expNum(32'd3); expOp(CO_MU); expEnd();
        applyStimulus(TK_OP, CO_LP, '0);
        checkOutput("lp_ready_next", 64'(in_ready), 64'd1);
        applyStimulus(TK_NUM, '0, 32'd1);
        applyStimulus(TK_OP, CO_AD, '0);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_OP, CO_RP, '0);
        applyStimulus(TK_OP, CO_MU, '0);
        applyStimulus(TK_NUM, '0, 32'd3);
        applyStimulus(TK_END, '0, '0);
        waitDrain("paren");
        checkOutput("paren_sp_empty", 64'(dut.sp), 64'd0);
        checkOutput("paren_err", 64'(err_seen), 64'd0);

        // 8 - 3 - 2 END : left associativity
        startCase();
        expNum(32'd8); expNum(32'd3); expOp(CO_SB); expNum(32'd2); expOp(CO_SB); expEnd();
        applyStimulus(TK_NUM, '0, 32'd8);
        applyStimulus(TK_OP, CO_SB, '0);
        applyStimulus(TK_NUM, '0, 32'd3);
        applyStimulus(TK_OP, CO_SB, '0);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_END, '0, '0);
        waitDrain("leftassoc");

        // 1 ) 2 END : unmatched close paren
        startCase();
        expNum(32'd1); expEnd();
        applyStimulus(TK_NUM, '0, 32'd1);
        applyStimulus(TK_OP, CO_RP, '0);
        checkOutput("rp_err_set", 64'(err), 64'd1);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_END, '0, '0);
        checkOutput("rp_err_held", 64'(err), 64'd1);
        waitDrain("rperr");
        checkOutput("rp_err_cleared", 64'(err), 64'd0);

        // five ( on a 4-deep stack
        startCase();
        expEnd();
        for (int i = 0; i < 4; i++) applyStimulus(TK_OP, CO_LP, '0);
        checkOutput("ovf_err_before", 64'(err), 64'd0);
        applyStimulus(TK_OP, CO_LP, '0);
        checkOutput("ovf_err_set", 64'(err), 64'd1);
        applyStimulus(TK_END, '0, '0);
        waitDrain("overflow");
        checkOutput("ovf_err_cleared", 64'(err), 64'd0);
        checkOutput("ovf_sp", 64'(dut.sp), 64'd0);

        // 1 + 2 * 3 END with out_ready toggling 1,0,0,1
        startCase();
        expNum(32'd1); expNum(32'd2); expNum(32'd3); expOp(CO_MU); expOp(CO_AD); expEnd();
        toggle_mode = 1'b1;
        sendSimple();
        waitDrain("backpressure");
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset while in PEND with three operators stacked
        startCase();
        applyStimulus(TK_OP, CO_LP, '0);
        applyStimulus(TK_OP, CO_LP, '0);
        applyStimulus(TK_OP, CO_LP, '0);
        applyStimulus(TK_OP, CO_AD, '0);
        checkOutput("pend_sp_before_rst", 64'(dut.sp), 64'd3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        checkOutput("midrst_out_fields", pack_tok(out_kind, out_op, out_data), 64'd0);
        checkOutput("midrst_sp", 64'(dut.sp), 64'd0);
        checkOutput("midrst_no_output", 64'(out_q.size()), 64'd0);
        startCase();
        expNum(32'd4); expNum(32'd2); expOp(CO_DI); expEnd();
        applyStimulus(TK_NUM, '0, 32'd4);
        applyStimulus(TK_OP, CO_DI, '0);
        applyStimulus(TK_NUM, '0, 32'd2);
        applyStimulus(TK_END, '0, '0);
        waitDrain("afterrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
